// File: rtl/prog_sequencer.sv
// Instruction-supply sequencer: loadable program memory feeding the processor's INST/CLB,
// stepping on a FETCH/EXEC rhythm and tracing each retired {PC, ACC} pair.
module prog_sequencer #(
    parameter int          PDEPTH  = 32,
    parameter int          TDEPTH  = 32,
    parameter logic [7:0]  HALT_OP = 8'hFF
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        load_en,
    input  logic [4:0]  load_addr,
    input  logic [7:0]  load_data,
    input  logic        run,
    input  logic [7:0]  PC,
    input  logic [7:0]  ACC,
    output logic [7:0]  INST,
    output logic        proc_CLB,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        trace_full,
    output logic [5:0]  trace_count,
    input  logic [4:0]  trace_rd_addr,
    output logic [15:0] trace_rd_data
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  mem   [PDEPTH];
    logic [15:0] trace [TDEPTH];
    logic [5:0]  cnt_inc;
    logic        start;
    logic        pc_bad;
    logic        is_halt;

    assign cnt_inc  = trace_count + 6'd1;
    assign start    = run && (state == IDLE || state == DONE);
    assign pc_bad   = (PC[7:5] != 3'd0);
    assign is_halt  = (INST == HALT_OP);
    assign busy     = (state == FETCH) || (state == EXEC);
    assign proc_CLB = busy;
    assign done     = (state == DONE);
    assign trace_rd_data = trace[trace_rd_addr];

    always_ff @(posedge clk) begin
        if (CLR) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (run) state_nxt = FETCH;
            FETCH:      state_nxt = EXEC;
            EXEC: begin
                if (is_halt || pc_bad || cnt_inc == 6'(TDEPTH)) state_nxt = DONE;
                else                                            state_nxt = FETCH;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // Control datapath; INST only changes on a run start or a FETCH-bound EXEC exit.
    always_ff @(posedge clk) begin
        if (CLR) begin
            INST        <= 8'h00;
            trace_count <= 6'd0;
            fault       <= 1'b0;
            trace_full  <= 1'b0;
        end else if (start) begin
            INST        <= mem[0];
            trace_count <= 6'd0;
            fault       <= 1'b0;
            trace_full  <= 1'b0;
        end else if (state == EXEC) begin
            if (trace_count != 6'(TDEPTH)) trace_count <= cnt_inc;
            if (!is_halt) begin
                if (pc_bad)                         fault      <= 1'b1;
                else if (cnt_inc == 6'(TDEPTH))     trace_full <= 1'b1;
                else                                INST       <= mem[PC[4:0]];
            end
        end
    end

    // Storage is never reset so programs and partial traces survive CLR.
    always_ff @(posedge clk) begin
        if (state == IDLE && load_en)
            mem[load_addr] <= load_data;
        if (!CLR && state == EXEC && trace_count != 6'(TDEPTH))
            trace[trace_count[4:0]] <= {PC, ACC};
    end

endmodule
